neuron_sample_feeder: RTL and testbench

NEURON_SAMPLE_FEEDER -- requirements
Module: neuron_sample_feeder

---
 rtl/neuron_sample_feeder_if.sv | 38 +++
 rtl/neuron_sample_feeder.sv | 151 +++++++++++++++
 tb/tb_neuron_sample_feeder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_sample_feeder_if.sv
// ============================================================================
// Module : neuron_sample_feeder_if
// Brief  : Sample-load / replay bus between the feeder and its neighbours.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface neuron_sample_feeder_if;
    logic        clear;
    logic        loadValid;
    logic        loadReady;
    logic [6:0]  loadX1;
    logic [6:0]  loadX2;
    logic [1:0]  loadT;
    logic        loadLast;
    logic        start;
    logic        stop;
    logic        next;
    logic        sampleValid;
    logic [6:0]  x1Out;
    logic [6:0]  x2Out;
    logic [1:0]  tOut;
    logic [31:0] nOut;
    logic        epochDone;
    logic [15:0] epochCount;

    modport slave (
        input  clear, loadValid, loadX1, loadX2, loadT, loadLast, start, stop, next,
        output loadReady, sampleValid, x1Out, x2Out, tOut, nOut, epochDone, epochCount
    );

    modport master (
        output clear, loadValid, loadX1, loadX2, loadT, loadLast, start, stop, next,
        input  loadReady, sampleValid, x1Out, x2Out, tOut, nOut, epochDone, epochCount
    );
endinterface

`default_nettype wire

// File: rtl/neuron_sample_feeder.sv
// ============================================================================
// Module : neuron_sample_feeder
// Brief  : Stores a training set of (x1, x2, t) samples and replays it in epochs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module neuron_sample_feeder #(
    parameter int DEPTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    neuron_sample_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   C_LAST_SLOT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   C_ONE_CNT   = (AW+1)'(1);
    localparam logic [AW-1:0] C_ONE_PTR   = AW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOADED = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t      state_q;
    logic [AW:0] count_q;
    logic [AW-1:0] rptr_q;
    logic        prime_q;
    logic        fetch_q;
    logic        valid_q;
    logic        epoch_done_q;
    logic [15:0] epoch_cnt_q;
    logic [6:0]  x1_q;
    logic [6:0]  x2_q;
    logic [1:0]  t_q;
    logic [15:0] mem_q [DEPTH];

    logic          load_ready;
    logic          accept;
    logic [AW:0]   count_d;
    logic [AW-1:0] rptr_d;
    logic          rptr_is_last;
    logic [15:0]   rd_word;

    assign load_ready   = (state_q == IDLE) || (state_q == LOAD);
    assign accept       = load_ready && bus.loadValid;
    assign count_d      = count_q + C_ONE_CNT;
    assign rptr_d       = rptr_q + C_ONE_PTR;
    assign rptr_is_last = ({1'b0, rptr_q} == (count_q - C_ONE_CNT));
    assign rd_word      = mem_q[rptr_q];

    // Storage is deliberately left out of reset and clear; count bounds what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[count_q[AW-1:0]] <= {bus.loadX1, bus.loadX2, bus.loadT};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rptr_q       <= '0;
            prime_q      <= 1'b0;
            fetch_q      <= 1'b0;
            valid_q      <= 1'b0;
            epoch_done_q <= 1'b0;
            epoch_cnt_q  <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            t_q          <= '0;
        end else begin
            epoch_done_q <= 1'b0;
            if (bus.clear) begin
                state_q     <= IDLE;
                count_q     <= '0;
                rptr_q      <= '0;
                prime_q     <= 1'b0;
                fetch_q     <= 1'b0;
                valid_q     <= 1'b0;
                epoch_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE, LOAD: begin
                        if (accept) begin
                            count_q <= count_d;
                            if (bus.loadLast || (count_q == C_LAST_SLOT)) begin
                                state_q <= LOADED;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                    LOADED: begin
                        if (bus.start) begin
                            state_q     <= RUN;
                            rptr_q      <= '0;
                            epoch_cnt_q <= '0;
                            prime_q     <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.stop) begin
                            state_q <= LOADED;
                            prime_q <= 1'b0;
                            fetch_q <= 1'b0;
                            valid_q <= 1'b0;
                        end else begin
                            // Start needs one extra settle cycle before the first fetch.
                            prime_q <= 1'b0;
                            fetch_q <= prime_q;
                            if (fetch_q) begin
                                x1_q    <= rd_word[15:9];
                                x2_q    <= rd_word[8:2];
                                t_q     <= rd_word[1:0];
                                valid_q <= 1'b1;
                            end
                            if (valid_q && bus.next) begin
                                valid_q <= 1'b0;
                                fetch_q <= 1'b1;
                                if (rptr_is_last) begin
                                    rptr_q       <= '0;
                                    epoch_done_q <= 1'b1;
                                    if (epoch_cnt_q != 16'hFFFF) begin
                                        epoch_cnt_q <= epoch_cnt_q + 16'd1;
                                    end
                                end else begin
                                    rptr_q <= rptr_d;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.loadReady   = load_ready;
    assign bus.sampleValid = valid_q;
    assign bus.x1Out       = x1_q;
    assign bus.x2Out       = x2_q;
    assign bus.tOut        = t_q;
    assign bus.nOut        = 32'(count_q);
    assign bus.epochDone   = epoch_done_q;
    assign bus.epochCount  = epoch_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_neuron_sample_feeder.sv
// ============================================================================
// Module : tb_neuron_sample_feeder
// Brief  : Directed bench for the sample feeder: load, replay, stop, clear, reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_neuron_sample_feeder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_failures;

    neuron_sample_feeder_if bus ();

    neuron_sample_feeder #(.DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input logic [6:0] x1, input logic [6:0] x2,
                             input logic [1:0] t, input logic last);
        bus.loadValid = 1'b1;
        bus.loadX1    = x1;
        bus.loadX2    = x2;
        bus.loadT     = t;
        bus.loadLast  = last;
        tick();
        bus.loadValid = 1'b0;
        bus.loadLast  = 1'b0;
    endtask

    task automatic check_sample(input string tag, input logic [6:0] x1,
                                input logic [6:0] x2, input logic [1:0] t);
        check_eq({tag, "_valid"}, bus.sampleValid, 1'b1);
        check_eq({tag, "_x1"}, bus.x1Out, x1);
        check_eq({tag, "_x2"}, bus.x2Out, x2);
        check_eq({tag, "_t"}, bus.tOut, t);
    endtask

    logic [6:0] ex1 [3];
    logic [6:0] ex2 [3];
    logic [1:0] ext [3];

    initial begin
        n_checks   = 0;
        n_failures = 0;
        ex1 = '{7'd5, 7'd120, 7'd64};
        ex2 = '{7'd9, 7'd3, 7'd64};
        ext = '{2'b01, 2'b11, 2'b01};

        rst = 1'b0;
        bus.clear = 0; bus.loadValid = 0; bus.loadX1 = 0; bus.loadX2 = 0;
        bus.loadT = 0; bus.loadLast = 0; bus.start = 0; bus.stop = 0; bus.next = 0;
        tick(); tick();
        check_eq("rst_valid", bus.sampleValid, 1'b0);
        check_eq("rst_nout", bus.nOut, 32'd0);
        check_eq("rst_epoch", bus.epochCount, 16'd0);
        check_eq("rst_x1", bus.x1Out, 7'd0);
        rst = 1'b1;
        tick();
        check_eq("rel_ready", bus.loadReady, 1'b1);

        // Three-sample set with loadLast on the final beat
        load_beat(7'd5, 7'd9, 2'b01, 1'b0);
        check_eq("load1_nout", bus.nOut, 32'd1);
        check_eq("load1_ready", bus.loadReady, 1'b1);
        load_beat(7'd120, 7'd3, 2'b11, 1'b0);
        load_beat(7'd64, 7'd64, 2'b01, 1'b1);
        check_eq("load3_nout", bus.nOut, 32'd3);
        check_eq("load3_ready", bus.loadReady, 1'b0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("start_lat0", bus.sampleValid, 1'b0);
        tick();
        check_eq("start_lat1", bus.sampleValid, 1'b0);
        tick();

        for (int i = 0; i < 7; i++) begin
            check_sample($sformatf("ep_s%0d", i), ex1[i % 3], ex2[i % 3], ext[i % 3]);
            bus.next = 1'b1;
            tick();
            bus.next = 1'b0;
            check_eq($sformatf("ep_done%0d", i), bus.epochDone, (i % 3) == 2);
            check_eq($sformatf("ep_gap%0d", i), bus.sampleValid, 1'b0);
            tick();
        end
        check_eq("ep_count2", bus.epochCount, 16'd2);
        check_sample("ep_after", ex1[1], ex2[1], ext[1]);

        // next held high: a sample every other cycle, none skipped
        bus.next = 1'b1;
        tick(); check_eq("hold_e1_valid", bus.sampleValid, 1'b0);
        tick(); check_eq("hold_e2_valid", bus.sampleValid, 1'b1);
                check_eq("hold_e2_x1", bus.x1Out, 7'd64);
        tick(); check_eq("hold_e3_valid", bus.sampleValid, 1'b0);
                check_eq("hold_e3_done", bus.epochDone, 1'b1);
        tick(); check_eq("hold_e4_x1", bus.x1Out, 7'd5);
                check_eq("hold_e4_done", bus.epochDone, 1'b0);
        tick(); check_eq("hold_e5_valid", bus.sampleValid, 1'b0);
        tick(); check_eq("hold_e6_x1", bus.x1Out, 7'd120);
                check_eq("hold_e6_valid", bus.sampleValid, 1'b1);
        bus.next = 1'b0;
        check_eq("hold_count3", bus.epochCount, 16'd3);

        // Reach the last sample, then stop and next together
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        tick();
        check_eq("last_x1", bus.x1Out, 7'd64);
        bus.stop = 1'b1; bus.next = 1'b1;
        tick();
        bus.stop = 1'b0; bus.next = 1'b0;
        check_eq("stop_valid", bus.sampleValid, 1'b0);
        check_eq("stop_done", bus.epochDone, 1'b0);
        check_eq("stop_count", bus.epochCount, 16'd3);
        check_eq("stop_ready", bus.loadReady, 1'b0);
        tick();
        check_eq("stop_hold_x1", bus.x1Out, 7'd64);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check_eq("loaded_next_ign", bus.sampleValid, 1'b0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check_sample("restart", ex1[0], ex2[0], ext[0]);
        check_eq("restart_count", bus.epochCount, 16'd0);

        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.clear = 1'b1; bus.start = 1'b1;
        tick();
        bus.clear = 1'b0; bus.start = 1'b0;
        check_eq("clr_nout", bus.nOut, 32'd0);
        check_eq("clr_ready", bus.loadReady, 1'b1);
        check_eq("clr_valid", bus.sampleValid, 1'b0);

        // Fill to DEPTH without loadLast; the extra beat must be refused
        for (int i = 0; i < 64; i++) begin
            load_beat(7'(i), 7'(i + 1), 2'b01, 1'b0);
            if (i == 62) begin
                check_eq("fill63_ready", bus.loadReady, 1'b1);
                check_eq("fill63_nout", bus.nOut, 32'd63);
            end
        end
        check_eq("fill64_ready", bus.loadReady, 1'b0);
        check_eq("fill64_nout", bus.nOut, 32'd64);
        load_beat(7'd127, 7'd127, 2'b11, 1'b0);
        check_eq("fill65_nout", bus.nOut, 32'd64);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check_sample("fill_first", 7'd0, 7'd1, 2'b01);

        // Asynchronous reset in the middle of a run
        #1 rst = 1'b0;
        #1;
        check_eq("arst_valid", bus.sampleValid, 1'b0);
        check_eq("arst_x1", bus.x1Out, 7'd0);
        check_eq("arst_t", bus.tOut, 2'd0);
        check_eq("arst_nout", bus.nOut, 32'd0);
        check_eq("arst_count", bus.epochCount, 16'd0);
        tick();
        rst = 1'b1;
        tick();
        check_eq("arst_rel_ready", bus.loadReady, 1'b1);

        // Single-sample set wraps on every next
        load_beat(7'd33, 7'd44, 2'b11, 1'b1);
        check_eq("one_nout", bus.nOut, 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check_sample("one_s0", 7'd33, 7'd44, 2'b11);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check_eq("one_done", bus.epochDone, 1'b1);
        tick();
        check_sample("one_s1", 7'd33, 7'd44, 2'b11);
        check_eq("one_count", bus.epochCount, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end
endmodule

`default_nettype wire
